// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;
    localparam int unsigned PC_W        = 64;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_delay_counter.sv
// Counts the edges an address has been presented to instruction memory;
// done marks the edge on which the returned word may be captured.
module fetch_delay_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_resetl,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_resetl || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, waits out the memory read delay, hands words
// to decode over valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     WAIT_CYCLES = 2,
    parameter logic [PC_W-1:0] MEM_BYTES   = 64'h58
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [PC_W-1:0]    startpc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               fault
);
    fetch_state_t        r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt, r_instr_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                w_misalign, w_oor, w_xfer, w_done;
    logic                w_capture, w_cnt_clr, w_cnt_en;

    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_oor      = (r_pc >= MEM_BYTES);

    fetch_delay_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_delay (
        .i_clk   (CLK),
        .i_resetl(resetl),
        .i_clear (w_cnt_clr),
        .i_enable(w_cnt_en),
        .o_done  (w_done)
    );

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Misaligned redirect beats everything; a redirect beside a transfer wins over pc+4.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            WAIT: begin
                if (w_oor || w_misalign) begin
                    w_state_nxt = FAULT;
                end else if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end else if (w_done) begin
                    w_state_nxt = VALID;
                end
            end
            VALID: begin
                if (w_misalign) begin
                    w_state_nxt = FAULT;
                end else if (redirect) begin
                    w_state_nxt = WAIT;
                    w_pc_nxt    = redirect_pc;
                end else if (instr_ready) begin
                    w_state_nxt = WAIT;
                    w_pc_nxt    = r_pc + PC_W'(INSTR_BYTES);
                end
            end
            default: w_state_nxt = FAULT;
        endcase
    end

    always_comb begin
        instr_valid = (r_state == VALID);
        fault       = (r_state == FAULT);
        w_xfer      = instr_valid && instr_ready;
        w_capture   = (r_state == WAIT) && (w_state_nxt == VALID);
        w_cnt_en    = (r_state == WAIT);
        w_cnt_clr   = (w_state_nxt != WAIT) || (redirect && r_state != FAULT);
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_pc       <= startpc;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_capture) begin
                r_instr    <= imem_data;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign instr_pc  = r_instr_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched, r_perf_stall;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else if (r_state != FAULT) begin
            if (w_xfer && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (instr_valid && !instr_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit against a fetch-level reference model.
// Perf counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch_unit;
    localparam int unsigned WAITC = 2;
    localparam logic [63:0] MEMB  = 64'h58;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic [63:0] startpc = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:21];

    // Reference state: what decode should see, tracked per fetch rather than per FSM state.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_fault;
    int          m_age;
    logic [31:0] m_fetched, m_stall;

    instruction_fetch_unit #(
        .WAIT_CYCLES(WAITC),
        .MEM_BYTES  (MEMB)
    ) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .startpc    (startpc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .fault      (fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [4:0] idx;
        idx = a[6:2];
        return (a < MEMB) ? mem[idx] : 32'h0;
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!resetl) begin
            m_pc = startpc; m_age = 0; m_valid = 0; m_instr = '0; m_ipc = '0; m_fault = 0;
            m_fetched = '0; m_stall = '0;
            return;
        end
        if (m_fault) return;
        if (m_valid && instr_ready) m_fetched++;
        if (m_valid && !instr_ready) m_stall++;
        if (m_valid) begin
            if (redirect && redirect_pc[1:0] != 2'b00) begin
                m_fault = 1; m_valid = 0;
            end else if (redirect) begin
                m_pc = redirect_pc; m_age = 0; m_valid = 0;
            end else if (instr_ready) begin
                m_pc = m_pc + 64'd4; m_age = 0; m_valid = 0;
            end
        end else begin
            if (m_pc >= MEMB || (redirect && redirect_pc[1:0] != 2'b00)) begin
                m_fault = 1;
            end else if (redirect) begin
                m_pc = redirect_pc; m_age = 0;
            end else begin
                m_age++;
                if (m_age == WAITC) begin
                    m_valid = 1; m_instr = mem_word(m_pc); m_ipc = m_pc;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
        check("fault", {63'd0, fault}, {63'd0, m_fault});
        check("instr", {32'd0, instr}, {32'd0, m_instr});
        check("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
        check("perf_stall", {32'd0, perf_stall}, {32'd0, m_stall});
`endif
    endtask

    task automatic step(input logic rst_n, input logic rdy, input logic rd, input logic [63:0] rpc);
        resetl = rst_n; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input logic [63:0] spc);
        startpc = spc;
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [63:0] rpc;
        int          r;
        for (int i = 0; i < 22; i++) mem[i] = 32'h9100_0000 + 32'(i * 32'h0001_1111);
        mem[0]  = 32'hF84003E9; mem[1]  = 32'hF84083EA; mem[5]  = 32'hAA0B014A;
        mem[8]  = 32'h8B0901AD; mem[13] = 32'hD29BDE0A; mem[20] = 32'hF80283E9;
        mem[21] = 32'hF84283EA;
        m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 0; m_fault = 0; m_age = 0;
        m_fetched = '0; m_stall = '0;

        // Back-to-back fetches from 0.
        do_reset(64'h0);
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        check("first_word", {32'd0, instr}, 64'hF84003E9);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
        check("second_word", {32'd0, instr}, 64'hF84083EA);

        // Stall at 0x14 for five cycles, then accept.
        do_reset(64'h14);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, '0);
        check("stall_hold", {32'd0, instr}, 64'hAA0B014A);
        step(1, 1, 0, '0);
        check("after_stall_pc", imem_addr, 64'h18);

        // Redirect mid-wait, then redirect coincident with a transfer.
        do_reset(64'h28);
        step(1, 1, 1, 64'h20);
        for (int i = 0; i < 2; i++) step(1, 1, 0, '0);
        check("redirect_word", {32'd0, instr}, 64'h8B0901AD);
        do_reset(64'h24);
        step(1, 1, 0, '0);
        step(1, 0, 0, '0);
        step(1, 1, 1, 64'h1C);
        check("redir_xfer_pc", imem_addr, 64'h1C);

        // Misaligned redirect: terminal fault until reset.
        step(1, 1, 1, 64'h22);
        check("misalign_fault", {63'd0, fault}, 64'd1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 64'h8);

        // Run off the end of populated memory.
        do_reset(64'h50);
        for (int i = 0; i < 10; i++) step(1, 1, 0, '0);
        check("end_fault", {63'd0, fault}, 64'd1);
        check("end_last_pc", instr_pc, 64'h54);

        // Reset while valid.
        do_reset(64'h40);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        startpc = 64'h34;
        step(0, 0, 0, '0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, '0);
        check("reset_refetch", {32'd0, instr}, 64'hD29BDE0A);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       rpc = {57'd0, 5'($urandom_range(0, 21)), 2'b00};
            else if (r == 7) rpc = 64'h100;
            else if (r == 8) rpc = {57'd0, 5'($urandom_range(0, 21)), 2'($urandom_range(1, 3))};
            else             rpc = 64'hFFFF_FFFF_FFFF_FFFC;
            if ($urandom_range(0, 99) < 2)
                startpc = {57'd0, 5'($urandom_range(0, 21)), 2'b00};
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                 rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the read-only instruction memory interface.
- Owns the PC and drives the 64-bit byte address to instruction memory.
- Waits a fixed number of cycles for the memory's asynchronous read delay, then captures the 32-bit word.
- Presents the captured word to decode with a valid/ready handshake; accepts branch/CBZ redirects from execute.

Parameters:
- WAIT_CYCLES, 2, clock edges between address launch and data capture (≥1); must cover the memory read delay.
- MEM_BYTES, 64'h58, size of populated instruction space; a fetch at PC ≥ MEM_BYTES is a fault.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- resetl  input  1  synchronous, active-low reset
- startpc  input  64  PC loaded on reset
- imem_addr  output  64  byte address to instruction memory; equals the PC register
- imem_data  input  32  instruction word returned by memory
- instr  output  32  captured instruction
- instr_pc  output  64  address the current `instr` was fetched from
- instr_valid  output  1  `instr`/`instr_pc` valid for decode
- instr_ready  input  1  decode accepts; a transfer occurs when valid && ready at an edge
- redirect  input  1  take `redirect_pc` as the next fetch address
- redirect_pc  input  64  branch/CBZ target
- fault  output  1  sticky; set on misaligned redirect or out-of-range PC

Behaviour:
- Reset: `resetl` sampled low at an edge gives pc=startpc, state=WAIT, cnt=0, instr=0, instr_pc=0, instr_valid=0, fault=0.
  - Reset overrides everything, including mid-WAIT, VALID or FAULT.
- States: WAIT, VALID, FAULT. `imem_addr` is always the pc register; it only changes at edges.
- WAIT:
  - If cnt==WAIT_CYCLES-1: capture instr=imem_data, instr_pc=pc, state=VALID. Otherwise cnt+=1.
  - First instr_valid is WAIT_CYCLES edges after reset release.
- VALID:
  - instr_valid=1; instr and instr_pc are held stable while ready=0.
  - On transfer: pc=pc+4 (64-bit, wrap modulo 2^64), cnt=0, state=WAIT.
  - Throughput is one instruction per WAIT_CYCLES+1 cycles when ready stays high.
- Redirect, in WAIT or VALID: pc=redirect_pc, cnt=0, state=WAIT, instr_valid=0 next cycle.
  - Any in-flight or unaccepted fetch is discarded.
  - Redirect and transfer in the same cycle: the transfer completes, and redirect_pc (not pc+4) becomes the next pc.
- Fault checks:
  - Misaligned redirect (redirect_pc[1:0]≠0): state=FAULT, fault=1, instr_valid=0, pc unchanged.
  - Any pc ≥ MEM_BYTES on entry to WAIT, whether after reset, increment or redirect: state=FAULT the next edge, without capture.
- FAULT is terminal until reset. redirect and instr_ready are ignored; outputs are held.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0.
  - perf_fetched counts transfers.
  - perf_stall counts cycles with instr_valid=1 && instr_ready=0.
  - Both counters saturate at 32'hFFFFFFFF and freeze in FAULT.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - state enum {WAIT, VALID, FAULT}
  - INSTR_BYTES=4
  - PC_W=64, INSTR_W=32
- One sub-module, fetch_delay_counter: clear, enable, and done when count==WAIT_CYCLES-1, parameterised by WAIT_CYCLES. The top level holds the PC, capture registers and FSM.

Test Plan:
- Reset release, startpc=0, memory model returns 32'hF84003E9 at 0 and 32'hF84083EA at 4, ready=1 → valid after 2 edges with instr=F84003E9, pc=0; next valid 3 edges later with F84083EA, pc=4.
- Hold ready=0 for 5 cycles in VALID at pc=0x14 → instr=AA0B014A and instr_pc=0x14 are stable throughout; perf_stall=5 when FETCH_PERF_CNT_EN is defined; then ready=1 → pc advances to 0x18.
- Redirect to 0x20 mid-WAIT at pc=0x28 → the 0x28 fetch is dropped; next valid gives instr=8B0901AD, pc=0x20. Also, redirect to 0x1C coincident with a transfer at 0x24 → that transfer counts and the next fetch is 0x1C.
- redirect_pc=0x22 → fault=1 next edge, instr_valid=0; later redirects are ignored; a reset pulse clears fault and refetches startpc.
- Sequential run with MEM_BYTES=0x58 from pc=0x50 → 0x50 and 0x54 are delivered (F80283E9, F84283EA); pc=0x58 raises fault with no third valid.
- resetl low for one edge while in VALID at pc=0x40 with startpc=0x34 → instr_valid=0, instr=0 next cycle; first valid has pc=0x34, instr=D29BDE0A.
